// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter sharing the single-port data memory between
// the CPU load/store stage (M0) and a debug/DMA master (M1).
// One transaction in flight at a time: IDLE -> ACCESS (gnt, DM access) -> RESP
// (rvalid, rdata/err). Misaligned or out-of-range accesses get err and never
// write the DM.
// Optional feature macro: DM_ARB_TRACE_EN prints one line per good store.
module dm_arbiter #(
  parameter int DEPTH_WORDS = 3072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_pc,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q;
  logic        last_q;      // id of the most recently granted master
  logic        id_q;        // id of the master owning the current transaction
  logic        we_q;
  logic        bad_q;
  logic        dm_we_q;
  logic [31:0] dm_addr_q;
  logic [31:0] dm_wdata_q;
  logic        m0_gnt_q, m1_gnt_q;
  logic        m0_rvalid_q, m1_rvalid_q;
  logic        err_q;

  logic        any_req_d;
  logic        win_d;
  logic        win_we_d;
  logic [31:0] win_addr_d;
  logic [31:0] win_wdata_d;
  logic        win_bad_d;

  // Round-robin pick of the winner and a mux of its request fields.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    any_req_d   = m0_req | m1_req;
    win_d       = (m0_req && m1_req) ? ~last_q : m1_req;
    win_we_d    = win_d ? m1_we    : m0_we;
    win_addr_d  = win_d ? m1_addr  : m0_addr;
    win_wdata_d = win_d ? m1_wdata : m0_wdata;
    win_bad_d   = (win_addr_d[1:0] != 2'b00) || (win_addr_d >= ADDR_LIMIT);
  end

  // Transaction FSM with all handshake and DM-side outputs registered.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;  // M0 wins the first tie after reset
      id_q        <= 1'b0;
      we_q        <= 1'b0;
      bad_q       <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Pulses default low; the state decode below raises them for one cycle.
      dm_we_q     <= 1'b0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          // A req still high in RESP is a fresh request, so both states arbitrate.
          if (any_req_d) begin
            state_q    <= ACCESS;
            id_q       <= win_d;
            last_q     <= win_d;
            we_q       <= win_we_d;
            bad_q      <= win_bad_d;
            dm_addr_q  <= win_addr_d;
            dm_wdata_q <= win_wdata_d;
            dm_we_q    <= win_we_d & ~win_bad_d;
            m0_gnt_q   <= ~win_d;
            m1_gnt_q   <= win_d;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          // The DM captures address/data (and performs the store) at this edge.
          state_q     <= RESP;
          m0_rvalid_q <= ~id_q;
          m1_rvalid_q <= id_q;
          err_q       <= bad_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // dm_rdata is only valid during RESP, so load data is passed through there.
  assign rdata     = (state_q == RESP && !we_q && !bad_q) ? dm_rdata : '0;
  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign err       = err_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;

`ifdef DM_ARB_TRACE_EN
  logic [31:0] pc_q;

  // Latch the PC alongside the request; M1 has no PC and traces as 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= '0;
    end else if (state_q != ACCESS && any_req_d) begin
      pc_q <= win_d ? 32'h0 : m0_pc;
    end
  end

  // Print each good store at the end-of-ACCESS edge where the DM writes it.
  always_ff @(posedge clk) begin
    if (dm_we_q) begin
      $display("@%h: *%h <= %h", pc_q, dm_addr_q, dm_wdata_q);
    end
  end
`else
  // The PC is consumed only by the trace.
  logic unused_pc;
  assign unused_pc = ^m0_pc;
`endif

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter placed in front of the single-port data memory (DM) of the P4 MIPS core. It shares the memory between the CPU load/store stage (M0) and a debug/DMA master (M1). Requests use a req/gnt/rvalid handshake and are granted round-robin, one transaction at a time. Misaligned or out-of-range accesses are rejected with an error response, and the block never writes the DM for them.

## Interface
- `DEPTH_WORDS`, 3072: DM size in 32-bit words; the valid byte range is 0 to DEPTH_WORDS*4-1.
- `clk  in  1`: system clock, rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `m0_req, m1_req  in  1`: request. Held high, with `we`/`addr`/`wdata` stable, until `gnt`.
- `m0_we, m1_we  in  1`: 1 = store word, 0 = load word.
- `m0_addr, m1_addr  in  32`: byte address.
- `m0_wdata, m1_wdata  in  32`: store data.
- `m0_pc  in  32`: PC of the M0 instruction. Used for trace only.
- `m0_gnt, m1_gnt  out  1`: one-cycle pulse. The request has been accepted.
- `m0_rvalid, m1_rvalid  out  1`: one-cycle pulse. The transaction is complete.
- `rdata  out  32`: load data, valid with `rvalid`.
- `err  out  1`: valid with `rvalid`. 1 = rejected (misaligned or out of range).
- `dm_we  out  1`: DM write enable.
- `dm_addr  out  32`: DM byte address.
- `dm_wdata  out  32`: DM write data.
- `dm_rdata  in  32`: DM read data. It reflects the address the DM captured at the previous rising edge.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high at the edge, latch the winner's we/addr/wdata/pc and its id, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Drive `dm_addr` and `dm_wdata` from the latched values.
  - Drive `dm_we` = latched_we & ~bad.
  - Assert `gnt` for the winner.
  - Go to RESP unconditionally.
- RESP:
  - Assert `rvalid` for the winner.
  - `rdata` = `dm_rdata` for a good load, otherwise 0.
  - `err` = bad.
  - Arbitrate again: if any req is high, latch the winner and go to ACCESS; otherwise go to IDLE.
- The `bad` condition is latched with the request: `addr[1:0] != 0` OR `addr >= DEPTH_WORDS*4`.
- Round-robin arbitration:
  - A `last` register holds the id of the most recently granted master.
  - If both req are high, the master that is not `last` wins.
  - A single requester always wins.
  - `last` is updated when a request is latched.
  - `last` resets to 1, so M0 wins the first tie.
- A requester must drop req in the cycle after `gnt`. A req still high in RESP is treated as a new request.
- Stores complete at the end-of-ACCESS edge. Stores still pulse `rvalid`, with `rdata` = 0.

## Timing
- Reset values, applied asynchronously while `rst` = 0:
  - State IDLE, `last` = 1.
  - All `gnt`, `rvalid`, `err` and `dm_we` = 0.
  - `rdata`, `dm_addr`, `dm_wdata` = 0.
- `dm_we` is high only in ACCESS. It is never high during or immediately after reset.
- Latency:
  - Request sampled at edge E.
  - `gnt` is high in cycle E+1 (ACCESS).
  - `rvalid` is high in cycle E+2 (RESP).
- Back-to-back requests reach ACCESS every 2 cycles.
- If reset is asserted in ACCESS or RESP:
  - The transaction is dropped with no `rvalid`.
  - `dm_we` falls immediately.
  - The requester must re-issue after reset.
- Outputs in IDLE: `dm_addr` holds its last value, and `dm_we` = 0.
- Both req rise in the same cycle: exactly one `gnt` is issued. The other master is served in the next ACCESS without any intervening IDLE.

## Configuration
- Macro `DM_ARB_TRACE_EN`.
- Defined: on every good store, at the end-of-ACCESS edge, print `$display("@%h: *%h <= %h", pc, dm_addr, dm_wdata)`.
  - `pc` is the latched `m0_pc` for M0.
  - `pc` is 0 for M1.
- Undefined: no trace logic is compiled in. Behaviour is otherwise identical.

## Test plan
- Reset then idle: hold `rst` = 0 for 3 cycles, then release. Required: all outputs 0 and `dm_we` never asserted.
- M0 store then load:
  - Store 0x00000010 <= 0xDEADBEEF. Required: `m0_gnt` at E+1, `dm_we` = 1 at E+1, `m0_rvalid` at E+2, `err` = 0.
  - Then load 0x10. Required: `rdata` = 0xDEADBEEF at `rvalid`.
- Simultaneous requests: both req high from reset release. Required:
  - Grants in order M0, M1, M0, M1 over 8 cycles.
  - `gnt` and `rvalid` are one-hot and pulse every 2 cycles.
- Error cases:
  - M1 store to 0x00000013 (misaligned). Required: `err` = 1, `rdata` = 0, `dm_we` never 1, DM word 0x10 unchanged.
  - Load from 0x00003000. Required: `err` = 1.
- Reset mid-transaction: assert `rst` = 0 during ACCESS of a store. Required: `dm_we` drops within the same cycle, no `rvalid` is issued, and the FSM is in IDLE after release.
- Trace, with `DM_ARB_TRACE_EN` defined: M0 store with `m0_pc` = 0x00003004 to 0x8 with data 0x5. Required: exactly one line `@00003004: *00000008 <= 00000005`.
